// File: rtl/tdm_demux.sv
// TDM receive demultiplexer: collects one word per channel into a shadow buffer
// and presents the whole frame at once. Optional parity: define TDM_DEMUX_PARITY_EN.
module tdm_demux #(
  parameter int N_CH = 4,
  parameter int W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [W-1:0]      in_data,
`ifdef TDM_DEMUX_PARITY_EN
  input  logic              in_par,
  output logic              par_err,
`endif
  output logic [N_CH*W-1:0] out_data,
  output logic              out_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_CH - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, RECV = 1'b1} state_t;

  state_t                  state_r, state_nxt_s;
  logic [IW-1:0]           idx_r, idx_nxt_s, widx_s;
  logic [N_CH-1:0][W-1:0]  shadow_r, shadow_nxt_s;
  logic                    beat_ok_s, perr_s, store_s, done_s, err_s;

`ifdef TDM_DEMUX_PARITY_EN
  function automatic logic even_par_ok(input logic [W-1:0] d, input logic p);
    return ~(^{d, p});
  endfunction

  // Parity-failing beats are rejected before the frame logic sees them.
  always_comb begin
    perr_s    = in_valid & ~even_par_ok(in_data, in_par);
    beat_ok_s = in_valid & ~perr_s;
  end
`else
  // Every qualified beat is accepted when parity is not built in.
  always_comb begin
    perr_s    = 1'b0;
    beat_ok_s = in_valid;
  end
`endif

  // Next-state, shadow write and completion decode.
  always_comb begin
    state_nxt_s  = state_r;
    idx_nxt_s    = idx_r;
    widx_s       = '0;
    store_s      = 1'b0;
    done_s       = 1'b0;
    err_s        = 1'b0;
    if (perr_s) begin
      state_nxt_s = IDLE;
      idx_nxt_s   = '0;
    end else if (beat_ok_s) begin
      case (state_r)
        IDLE: begin
          if (in_sof) begin
            store_s = 1'b1;
            widx_s  = '0;
          end else begin
            store_s = 1'b0;
          end
        end
        RECV: begin
          store_s = 1'b1;
          if (in_sof) begin
            err_s  = 1'b1;
            widx_s = '0;
          end else begin
            widx_s = idx_r;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          idx_nxt_s   = '0;
        end
      endcase
      // A stored word either finishes the frame or advances the channel index.
      if (store_s && (widx_s == LAST_IDX)) begin
        done_s      = 1'b1;
        state_nxt_s = IDLE;
        idx_nxt_s   = '0;
      end else if (store_s) begin
        state_nxt_s = RECV;
        idx_nxt_s   = widx_s + IW'(1);
      end else begin
        idx_nxt_s = idx_r;
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Shadow image including the word being written this cycle.
  always_comb begin
    shadow_nxt_s = shadow_r;
    if (store_s) begin
      shadow_nxt_s[widx_s] = in_data;
    end else begin
      shadow_nxt_s = shadow_r;
    end
  end

  // State, buffer and registered output pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      idx_r     <= '0;
      shadow_r  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else begin
      state_r   <= state_nxt_s;
      idx_r     <= idx_nxt_s;
      shadow_r  <= shadow_nxt_s;
      out_valid <= done_s;
      frame_err <= err_s;
`ifdef TDM_DEMUX_PARITY_EN
      par_err   <= perr_s;
`endif
      if (done_s) begin
        out_data <= shadow_nxt_s;
      end
    end
  end

  assign busy = (state_r == RECV);

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux (N_CH=4, W=8) using an expected-frame scoreboard.
module tb_tdm_demux;
  localparam int N_CH = 4;
  localparam int W    = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_sof = 1'b0;
  logic [W-1:0]      in_data = '0;
  logic [N_CH*W-1:0] out_data;
  logic              out_valid, frame_err, busy;
`ifdef TDM_DEMUX_PARITY_EN
  logic              in_par = 1'b0;
  logic              par_err;
`endif

  int tests = 0;
  int fails = 0;
  int n_valid = 0;
  int n_ferr = 0;
  logic [N_CH*W-1:0] exp_q[$];

  tdm_demux #(.N_CH(N_CH), .W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
`ifdef TDM_DEMUX_PARITY_EN
    .in_par(in_par), .par_err(par_err),
`endif
    .out_data(out_data), .out_valid(out_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [N_CH*W-1:0] pack4(input logic [7:0] c0, c1, c2, c3);
    return {c3, c2, c1, c0};
  endfunction

  // Scoreboard: every out_valid pulse must match the oldest expected frame.
  always @(posedge clk) begin
    #1;
    if (frame_err === 1'b1) n_ferr++;
    if (out_valid === 1'b1) begin
      n_valid++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: out_data=%h, no frame expected", out_data);
      end else begin
        logic [N_CH*W-1:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          fails++;
          $display("FAIL sb_data: got %h expected %h", out_data, e);
        end
      end
    end
  end

  task automatic beat(input logic sof, input logic [7:0] d);
    @(negedge clk);
    in_valid = 1'b1; in_sof = sof; in_data = d;
`ifdef TDM_DEMUX_PARITY_EN
    in_par = ^d;
`endif
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0; in_sof = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests++;
      if (out_data !== '0 || out_valid !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL reset_idle: data=%h valid=%b busy=%b expected 0/0/0", out_data, out_valid, busy);
      end
    end
  endtask

  task automatic test_single;
    int v0;
    v0 = n_valid;
    exp_q.push_back(pack4(8'h11, 8'h22, 8'h33, 8'h44));
    beat(1'b1, 8'h11);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy0: got %b expected 1", busy); end
    beat(1'b0, 8'h22);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy1: got %b expected 1", busy); end
    beat(1'b0, 8'h33);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy2: got %b expected 1", busy); end
    beat(1'b0, 8'h44);
    tests++;
    if (out_valid !== 1'b1 || busy !== 1'b0 || out_data !== 32'h44332211) begin
      fails++;
      $display("FAIL single_done: valid=%b busy=%b data=%h expected 1/0/44332211", out_valid, busy, out_data);
    end
    idle(1);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_pulse: valid=%b expected 0", out_valid); end
    idle(1);
    tests++; if (n_valid - v0 != 1) begin fails++; $display("FAIL single_count: got %0d expected 1", n_valid - v0); end
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = n_valid;
    exp_q.push_back(pack4(8'h11, 8'h22, 8'h33, 8'h44));
    beat(1'b1, 8'h11); beat(1'b0, 8'h22); beat(1'b0, 8'h33); beat(1'b0, 8'h44);
    exp_q.push_back(pack4(8'hA1, 8'hA2, 8'hA3, 8'hA4));
    beat(1'b1, 8'hA1);
    idle(1);
    beat(1'b0, 8'hA2);
    idle(2);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_gap_busy: got %b expected 1", busy); end
    beat(1'b0, 8'hA3); beat(1'b0, 8'hA4);
    idle(2);
    tests++; if (n_valid - v0 != 2) begin fails++; $display("FAIL b2b_count: got %0d expected 2", n_valid - v0); end
    tests++; if (out_data !== 32'hA4A3A2A1) begin fails++; $display("FAIL b2b_data: got %h expected a4a3a2a1", out_data); end
  endtask

  task automatic test_premature;
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    beat(1'b1, 8'h01); beat(1'b0, 8'h02);
    exp_q.push_back(pack4(8'h10, 8'h20, 8'h30, 8'h40));
    beat(1'b1, 8'h10);
    tests++;
    if (frame_err !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL prem_err: frame_err=%b busy=%b expected 1/1", frame_err, busy);
    end
    beat(1'b0, 8'h20); beat(1'b0, 8'h30); beat(1'b0, 8'h40);
    idle(2);
    tests++; if (n_ferr - f0 != 1) begin fails++; $display("FAIL prem_errcount: got %0d expected 1", n_ferr - f0); end
    tests++; if (n_valid - v0 != 1) begin fails++; $display("FAIL prem_count: got %0d expected 1", n_valid - v0); end
    tests++; if (out_data !== 32'h40302010) begin fails++; $display("FAIL prem_data: got %h expected 40302010", out_data); end
  endtask

  task automatic test_no_sof;
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    beat(1'b0, 8'h55); beat(1'b0, 8'h66);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL nosof_busy: got %b expected 0", busy); end
    exp_q.push_back(pack4(8'hC0, 8'hC1, 8'hC2, 8'hC3));
    beat(1'b1, 8'hC0); beat(1'b0, 8'hC1); beat(1'b0, 8'hC2); beat(1'b0, 8'hC3);
    idle(2);
    tests++; if (n_ferr != f0) begin fails++; $display("FAIL nosof_err: got %0d expected 0", n_ferr - f0); end
    tests++; if (n_valid - v0 != 1) begin fails++; $display("FAIL nosof_count: got %0d expected 1", n_valid - v0); end
    tests++; if (out_data !== 32'hC3C2C1C0) begin fails++; $display("FAIL nosof_data: got %h expected c3c2c1c0", out_data); end
  endtask

  task automatic test_reset_mid;
    int v0;
    v0 = n_valid;
    beat(1'b1, 8'h77); beat(1'b0, 8'h78);
    @(negedge clk);
    in_valid = 1'b0; in_sof = 1'b0; rst = 1'b1;
    #1;
    tests++;
    if (out_data !== '0 || busy !== 1'b0 || out_valid !== 1'b0 || frame_err !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_outputs: data=%h busy=%b valid=%b ferr=%b expected all 0", out_data, busy, out_valid, frame_err);
    end
    @(negedge clk); rst = 1'b0;
    beat(1'b0, 8'h79);
    exp_q.push_back(pack4(8'hEF, 8'hBE, 8'hAD, 8'hDE));
    beat(1'b1, 8'hEF); beat(1'b0, 8'hBE); beat(1'b0, 8'hAD); beat(1'b0, 8'hDE);
    idle(2);
    tests++; if (n_valid - v0 != 1) begin fails++; $display("FAIL rstmid_count: got %0d expected 1", n_valid - v0); end
    tests++; if (out_data !== 32'hDEADBEEF) begin fails++; $display("FAIL rstmid_data: got %h expected deadbeef", out_data); end
  endtask

`ifdef TDM_DEMUX_PARITY_EN
  task automatic test_parity;
    int v0;
    v0 = n_valid;
    beat(1'b1, 8'h01); beat(1'b0, 8'h02);
    @(negedge clk);
    in_valid = 1'b1; in_sof = 1'b0; in_data = 8'h03; in_par = ~(^in_data);
    @(posedge clk); #1;
    tests++;
    if (par_err !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL par_err: par_err=%b busy=%b expected 1/0", par_err, busy);
    end
    beat(1'b0, 8'h04);
    idle(2);
    tests++; if (n_valid != v0) begin fails++; $display("FAIL par_novalid: got %0d expected 0", n_valid - v0); end
    tests++; if (out_data !== 32'hDEADBEEF) begin fails++; $display("FAIL par_hold: got %h expected deadbeef", out_data); end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_premature;
    test_no_sof;
    test_reset_mid;
`ifdef TDM_DEMUX_PARITY_EN
    test_parity;
`endif
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: %0d frames never produced, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
